// File: rtl/common.sv
// Shared types for the memory stage: opcodes, data-bus structs, FSM states
// and small decode helpers.
package common;

  typedef logic [63:0] u64;

  typedef enum logic [4:0] {
    NOP, ADD, SUB, BEQ,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD
  } OPC;

  typedef enum logic [1:0] {
    MSIZE1, MSIZE2, MSIZE4, MSIZE8
  } msize_t;

  typedef struct packed {
    logic       valid;
    u64         addr;
    msize_t     size;
    logic [7:0] strobe;
    u64         data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE, REQ, DONE
  } mau_state_t;

  function automatic logic is_load(input OPC op);
    return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
  endfunction

  function automatic logic is_store(input OPC op);
    return op inside {SB, SH, SW, SD};
  endfunction

  function automatic msize_t op_size(input OPC op);
    unique case (op)
      LB, LBU, SB: return MSIZE1;
      LH, LHU, SH: return MSIZE2;
      LW, LWU, SW: return MSIZE4;
      default:     return MSIZE8;
    endcase
  endfunction

  function automatic logic [7:0] strobe_base(input msize_t sz);
    unique case (sz)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic addr_aligned(input msize_t sz, input logic [2:0] off);
    unique case (sz)
      MSIZE1:  return 1'b1;
      MSIZE2:  return off[0] == 1'b0;
      MSIZE4:  return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/response pair between the memory stage and the data memory.
interface mem_access_unit_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/load_extend.sv
// Selects the addressed lane of a returned bus word and sign/zero-extends it.
module load_extend
  import common::*;
(
  input  OPC         op_i,
  input  logic [2:0] off_i,
  input  u64         data_i,
  output u64         data_o
);

  u64 lane;

  always_comb begin
    lane   = data_i >> {off_i, 3'b000};
    data_o = '0;
    unique case (op_i)
      LB:      data_o = {{56{lane[7]}},  lane[7:0]};
      LH:      data_o = {{48{lane[15]}}, lane[15:0]};
      LW:      data_o = {{32{lane[31]}}, lane[31:0]};
      LBU:     data_o = {56'd0, lane[7:0]};
      LHU:     data_o = {48'd0, lane[15:0]};
      LWU:     data_o = {32'd0, lane[31:0]};
      LD:      data_o = lane;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: issues one data-bus request per memory op,
// holds it until data_ok, and presents the extended load result.
module mem_access_unit
  import common::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  OPC                        op,
  input  u64                        addr,
  input  u64                        store_data,
  input  logic                      advance,
  mem_access_unit_if.master         dbus,
  output u64                        mem_read_data,
  output logic                      done,
  output logic                      stall,
  output logic                      misalign
);

  mau_state_t state_q;
  dbus_req_t  req_q;
  OPC         op_q;
  u64         rdata_q;

  dbus_req_t  req_d;
  msize_t     size_d;
  logic       mem_op;
  logic       aligned;
  logic       accept;
  u64         ext_data;

  always_comb begin
    size_d  = op_size(op);
    mem_op  = is_load(op) || is_store(op);
    aligned = addr_aligned(size_d, addr[2:0]);
    accept  = (state_q == IDLE) && valid_in && mem_op && aligned;

    req_d        = '0;
    req_d.valid  = 1'b1;
    req_d.addr   = addr;
    req_d.size   = size_d;
    req_d.strobe = is_store(op) ? (strobe_base(size_d) << addr[2:0]) : 8'h00;
    req_d.data   = store_data << {addr[2:0], 3'b000};
  end

  // Extension uses the latched offset so it stays tied to the outstanding request.
  load_extend u_load_extend (
    .op_i   (op_q),
    .off_i  (req_q.addr[2:0]),
    .data_i (dbus.dresp.data),
    .data_o (ext_data)
  );

  always_comb begin
    done     = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
    unique case (state_q)
      IDLE: begin
        done     = valid_in && !(mem_op && aligned);
        misalign = valid_in && mem_op && !aligned;
        stall    = accept;
      end
      REQ:  stall = 1'b1;
      DONE: begin
        done  = 1'b1;
        stall = !advance;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      op_q    <= NOP;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          req_q   <= req_d;
          op_q    <= op;
          state_q <= REQ;
        end
        REQ: if (dbus.dresp.data_ok) begin
          rdata_q     <= ext_data;
          req_q.valid <= 1'b0;
          state_q     <= DONE;
        end
        DONE: if (advance) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbus.dreq     = req_q;
  assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected load results are queued at
// issue and compared when the unit reports done.
module tb_mem_access_unit;
  import common::*;

  logic clk = 1'b0;
  logic reset, valid_in, advance;
  OPC   op;
  u64   addr, store_data, mem_read_data;
  logic done, stall, misalign;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .op            (op),
    .addr          (addr),
    .store_data    (store_data),
    .advance       (advance),
    .dbus          (bus),
    .mem_read_data (mem_read_data),
    .done          (done),
    .stall         (stall),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  u64          exp_q[$];

  task automatic check_eq(input string tag, input u64 act, input u64 exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic run_txn(input OPC o, input u64 a, input u64 sd, input u64 rd,
                         input int dly, input int hold, input u64 exp_rd,
                         input logic [7:0] exp_stb, input u64 exp_wd,
                         input msize_t exp_sz);
    u64 exp;
    valid_in = 1'b1; op = o; addr = a; store_data = sd; advance = 1'b0;
    exp_q.push_back(exp_rd);
    #1;
    check_eq("stall_accept", u64'(stall), 64'd1);
    check_eq("done_idle", u64'(done), 64'd0);
    @(negedge clk);
    check_eq("req_valid", u64'(bus.dreq.valid), 64'd1);
    check_eq("req_addr", bus.dreq.addr, a);
    check_eq("req_size", u64'(bus.dreq.size), u64'(exp_sz));
    check_eq("req_strobe", u64'(bus.dreq.strobe), u64'(exp_stb));
    check_eq("req_data", bus.dreq.data, exp_wd);
    advance = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check_eq("req_hold_valid", u64'(bus.dreq.valid), 64'd1);
      check_eq("req_hold_addr", bus.dreq.addr, a);
      check_eq("req_hold_size", u64'(bus.dreq.size), u64'(exp_sz));
      check_eq("req_hold_strobe", u64'(bus.dreq.strobe), u64'(exp_stb));
      check_eq("req_hold_stall", u64'(stall), 64'd1);
      check_eq("req_hold_done", u64'(done), 64'd0);
    end
    advance = 1'b0;
    bus.dresp.data = rd; bus.dresp.addr_ok = 1'b1; bus.dresp.data_ok = 1'b1;
    @(negedge clk);
    bus.dresp = '0;
    check_eq("done_set", u64'(done), 64'd1);
    check_eq("req_dropped", u64'(bus.dreq.valid), 64'd0);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
      check_eq("rdata", mem_read_data, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_done", u64'(done), 64'd1);
      check_eq("hold_stall", u64'(stall), 64'd1);
      check_eq("hold_rdata", mem_read_data, exp);
    end
    advance = 1'b1; valid_in = 1'b0;
    #1;
    check_eq("stall_advance", u64'(stall), 64'd0);
    @(negedge clk);
    advance = 1'b0;
    #1;
    check_eq("idle_done", u64'(done), 64'd0);
    check_eq("idle_valid", u64'(bus.dreq.valid), 64'd0);
  endtask

  task automatic run_misaligned(input OPC o, input u64 a);
    valid_in = 1'b1; op = o; addr = a; store_data = 64'hFFFF;
    #1;
    check_eq("mis_flag", u64'(misalign), 64'd1);
    check_eq("mis_done", u64'(done), 64'd1);
    check_eq("mis_stall", u64'(stall), 64'd0);
    @(negedge clk);
    check_eq("mis_no_req", u64'(bus.dreq.valid), 64'd0);
    check_eq("mis_still_idle", u64'(misalign), 64'd1);
    valid_in = 1'b0;
    #1;
    check_eq("mis_clear", u64'(misalign), 64'd0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; advance = 1'b0; op = NOP;
    addr = '0; store_data = '0; bus.dresp = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", u64'(bus.dreq.valid), 64'd0);
    check_eq("rst_addr", bus.dreq.addr, 64'd0);
    check_eq("rst_strobe", u64'(bus.dreq.strobe), 64'd0);
    check_eq("rst_rdata", mem_read_data, 64'd0);
    check_eq("rst_done", u64'(done), 64'd0);
    check_eq("rst_stall", u64'(stall), 64'd0);
    check_eq("rst_misalign", u64'(misalign), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(LW,  64'h1004, 64'h0, 64'h8000_0001_0000_0000, 3, 4,
            64'hFFFF_FFFF_8000_0001, 8'h00, 64'h0, MSIZE4);
    run_txn(LBU, 64'h7, 64'h0, 64'hAB00_0000_0000_0000, 1, 0,
            64'h0000_0000_0000_00AB, 8'h00, 64'h0, MSIZE1);
    run_txn(LB,  64'h7, 64'h0, 64'hAB00_0000_0000_0000, 1, 0,
            64'hFFFF_FFFF_FFFF_FFAB, 8'h00, 64'h0, MSIZE1);
    run_txn(SH,  64'h2, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0,
            64'h0, 8'h0C, 64'h0000_0000_1234_0000, MSIZE2);
    run_txn(LD,  64'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1,
            64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, MSIZE8);
    run_txn(LHU, 64'h6, 64'h0, 64'hFEDC_0000_0000_0000, 0, 0,
            64'h0000_0000_0000_FEDC, 8'h00, 64'h0, MSIZE2);
    run_txn(LH,  64'h6, 64'h0, 64'hFEDC_0000_0000_0000, 0, 0,
            64'hFFFF_FFFF_FFFF_FEDC, 8'h00, 64'h0, MSIZE2);
    run_txn(LWU, 64'h4, 64'h0, 64'h8000_0001_0000_0000, 1, 0,
            64'h0000_0000_8000_0001, 8'h00, 64'h0, MSIZE4);
    run_txn(SB,  64'h5, 64'h5A, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
            64'h0, 8'h20, 64'h0000_5A00_0000_0000, MSIZE1);
    run_txn(SW,  64'h4, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0,
            64'h0, 8'hF0, 64'hDEAD_BEEF_0000_0000, MSIZE4);
    run_txn(SD,  64'h8, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
            64'h0, 8'hFF, 64'h1122_3344_5566_7788, MSIZE8);
    run_txn(LB,  64'h0, 64'h0, 64'h0000_0000_0000_007F, 2, 0,
            64'h0000_0000_0000_007F, 8'h00, 64'h0, MSIZE1);

    run_misaligned(LW, 64'h2);
    run_misaligned(LH, 64'h1);
    run_misaligned(SD, 64'h4);
    run_misaligned(LWU, 64'h3);

    // Non-memory op completes immediately without touching the bus.
    valid_in = 1'b1; op = ADD; addr = 64'h3;
    #1;
    check_eq("alu_done", u64'(done), 64'd1);
    check_eq("alu_stall", u64'(stall), 64'd0);
    check_eq("alu_misalign", u64'(misalign), 64'd0);
    @(negedge clk);
    check_eq("alu_no_req", u64'(bus.dreq.valid), 64'd0);
    valid_in = 1'b0;

    // Reset while a request is outstanding; the late response must be ignored.
    @(negedge clk);
    valid_in = 1'b1; op = LW; addr = 64'h100; store_data = '0;
    @(negedge clk);
    check_eq("rreq_valid", u64'(bus.dreq.valid), 64'd1);
    reset = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    check_eq("rreq_dropped", u64'(bus.dreq.valid), 64'd0);
    check_eq("rreq_addr", bus.dreq.addr, 64'd0);
    check_eq("rreq_stall", u64'(stall), 64'd0);
    reset = 1'b0;
    bus.dresp.data = 64'hDEAD_DEAD_DEAD_DEAD; bus.dresp.data_ok = 1'b1;
    @(negedge clk);
    bus.dresp = '0;
    check_eq("late_done", u64'(done), 64'd0);
    check_eq("late_valid", u64'(bus.dreq.valid), 64'd0);
    check_eq("late_rdata", mem_read_data, 64'd0);
    @(negedge clk);
    check_eq("late_idle_done", u64'(done), 64'd0);
    check_eq("late_idle_stall", u64'(stall), 64'd0);

    check_eq("scoreboard_drained", u64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine that produces the `mem_read_data` consumed by writeback data selection. It turns a memory-stage instruction into a data-bus transaction on `dreq`/`dresp` and holds the request stable until the response arrives. For loads it extracts and sign- or zero-extends the returned lane. While the access is outstanding it stalls the pipeline.

## Interface
Parameters: none. Widths come from `common`.

- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `valid_in` in 1: memory stage holds a valid instruction
- `op` in OPC: instruction opcode; LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD are memory ops
- `addr` in u64: effective address (ALU result)
- `store_data` in u64: rs2 value, unshifted
- `advance` in 1: pipeline accepts this stage's result this cycle
- `dreq` out dbus_req_t: valid, addr, size (msize_t), strobe, data
- `dresp` in dbus_resp_t: addr_ok, data_ok, data
- `mem_read_data` out u64: extended load result, valid while `done`
- `done` out 1: result for current instruction is available
- `stall` out 1: freeze upstream stages
- `misalign` out 1: current memory op is misaligned; no bus request is made

## Operation
- States: IDLE, REQ, DONE. The reset state is IDLE.
- IDLE:
  - If `valid_in` and `op` is a memory op and aligned: latch op, addr, size, strobe, shifted store data; go to REQ.
  - Non-memory op: `done`=`valid_in`, `stall`=0, and the state stays IDLE.
  - Misaligned memory op: `misalign`=1, `done`=1, no transition.
- Alignment:
  - Halfword needs `addr[0]`=0.
  - Word needs `addr[1:0]`=0.
  - Double needs `addr[2:0]`=0.
- REQ:
  - `dreq.valid`=1 with all fields driven from the latches, constant until `data_ok`.
  - On `dresp.data_ok`: latch the extended load data and go to DONE. `addr_ok` without `data_ok` keeps the unit in REQ.
- DONE: `done`=1 and `mem_read_data` is held. On `advance` go to IDLE.
- Size encoding (msize_t): B→MSIZE1, H→MSIZE2, W→MSIZE4, D→MSIZE8.
- Strobe and store data:
  - Base strobe is 8'h01 (B), 8'h03 (H), 8'h0F (W) or 8'hFF (D), shifted left by `addr[2:0]`.
  - `dreq.data` = `store_data` << (8·`addr[2:0]`).
- Loads:
  - `dreq.strobe`=0.
  - Lane = `dresp.data` >> (8·`addr[2:0]`), truncated to the access width.
  - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD passes through.
- Stores: `mem_read_data`=0. They still wait for `data_ok`.
- `stall` = (IDLE and `valid_in` and aligned memory op) or REQ or (DONE and !`advance`).

## Timing
- Reset values: state IDLE, `dreq.valid`=0, `dreq` fields 0, `mem_read_data`=0, `done`=0, `stall`=0, `misalign`=0.
- Latency: an op accepted in IDLE at cycle 0 asserts `dreq.valid` at cycle 1.
- `data_ok` at cycle k≥1 gives `done` at cycle k+1, so the minimum load-to-result time is 2 cycles.
- `data_ok` in the same cycle REQ is entered counts: the transition to DONE happens on that edge.
- `dreq` is driven only from registers, with no combinational path from `dresp` to `dreq`.
- `reset` asserted in REQ forces IDLE on the next edge, and `dreq.valid` drops that cycle. A late `data_ok` arriving in IDLE is ignored.
- `advance` in REQ is ignored: the instruction cannot leave while the access is outstanding.
- `advance` and a new `valid_in` in the same DONE cycle: go to IDLE. The new op is sampled the following cycle.

## Structure
- Shared package `common`: OPC, u64, msize_t, dbus_req_t, dbus_resp_t, and state enum `mau_state_t`.
- Add helpers to `common`: `is_load(op)`, `is_store(op)`, `op_size(op)`.
- One sub-module, `load_extend`: combinational lane select and extension from (op, addr[2:0], data).

## Test plan
- LW at addr 0x1004, `dresp.data`=0x8000_0001_0000_0000, `data_ok` 3 cycles after request:
  - `dreq.valid` stays high 3 cycles with addr, size and strobe constant.
  - Then `mem_read_data`=0xFFFF_FFFF_8000_0001 and `done`=1.
- LBU at addr 0x7 with data 0xAB00_0000_0000_0000 → `mem_read_data`=0xAB.
- LB with the same stimulus → 0xFFFF_FFFF_FFFF_FFAB.
- SH at addr 0x2, `store_data`=0x1234 → `dreq.strobe`=8'h0C, `dreq.data`=0x1234_0000, size MSIZE2.
- LW at addr 0x2 → `misalign`=1, `done`=1, `dreq.valid` never asserted, `stall`=0.
- `reset` pulsed during REQ → `dreq.valid`=0 next cycle, state IDLE; a later `data_ok` has no effect.
- `advance` held low 4 cycles in DONE → `mem_read_data` stable and `stall`=1 throughout; the first `advance` returns to IDLE.
